inv_add_mix_round: RTL and testbench
====================================

# inv_add_mix_round

Decryption round back-end for the Modified AES-256 datapath. It consumes the 128-bit state produced by the inverse SubBytes stage and XORs in the round key (AddRoundKey). It then applies InvMixColumns one column per clock, except on the final round. Results are presented to the round controller through a valid/ready handshake.

## Interface
Parameters:
- none. Widths are fixed at 128-bit state and 8-bit bytes.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_state/round_key/last_round are valid
- in_ready  output  1  block can accept a new state
- in_state  input  128  state from inverse SubBytes; byte k at [8k+7:8k]
- round_key  input  128  round key for this round, same byte order
- last_round  input  1  1 = AddRoundKey only, skip InvMixColumns
- out_valid  output  1  out_state holds a finished result
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  round result, same byte order

## Operation
- Byte mapping:
  - Byte k is in row k%4 and column k/4.
  - Column c = bytes 4c..4c+3, with byte 4c as row 0.
- FSM states: IDLE, CALC, DONE.
  - Reset state is IDLE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid&&in_ready, work register <= in_state ^ round_key and col <= 0.
  - If last_round=1, go to DONE. Otherwise go to CALC.
- CALC:
  - Each cycle, column col of work is replaced by InvMixColumns(column col).
  - col is a 2-bit counter. After col==3 is processed, go to DONE; col wraps to 0.
- InvMixColumns uses the GF(2^8) matrix [0e 0b 0d 09] with rotated rows, polynomial 0x11b.
  - Output row r = 0e·a_r ^ 0b·a_(r+1) ^ 0d·a_(r+2) ^ 09·a_(r+3), indices mod 4.
- DONE:
  - out_state = work, held stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE.
- in_valid is ignored outside IDLE. Inputs are sampled only on the accepting edge, so later changes have no effect.
- Reset asserted mid-operation aborts the block.
  - State returns to IDLE immediately (asynchronously); col=0.
  - The partial result is discarded and never emitted.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_state=128'h0, col=0.
- Non-last round: out_valid rises after the 5th rising edge counting the accepting edge (accept, then 4 column edges).
- Last round: out_valid rises after the accepting edge (1 edge).
- The output handshake edge returns the block to IDLE. in_ready is 1 in the next cycle.
  - The block does not accept a new input in the same cycle as the output handshake.
- Peak throughput is one block per 6 cycles (non-last) or per 2 cycles (last), with out_ready held at 1.
- No combinational path from in_valid or out_ready to in_ready or out_valid.

## Configuration
- AES_INVMIX_PARALLEL_EN defined:
  - Four inv_mix_column instances process all columns on the accepting edge.
  - CALC is never entered and col is unused.
  - Latency is 1 edge for both values of last_round.
- Macro undefined (default):
  - A single inv_mix_column instance is used, column-serial as described above.
  - Area is about 1/4 of the parallel build.
- The handshake, reset values and results are identical in both builds. Only latency differs.

## Structure
- Package aes_dec_pkg holds:
  - typedef state_t (logic [127:0]) and col_t (logic [31:0])
  - constant AES_POLY = 8'h1b
  - functions xtime, gmul_09/0b/0d/0e
  - enum for the FSM states
- Sub-module inv_mix_column: combinational, 32-bit column in and out, built from the package functions.
  - It is shared by this block and the key-schedule equivalent-inverse-cipher path.

## Test plan
- Reset: hold rst_n=0 → in_ready=1, out_valid=0, out_state=0.
  - Release, then idle 10 cycles → outputs unchanged.
- Known vector: every column = {bc,a1,4d,8e} (byte 4c=8e), round_key=0, last_round=0.
  - Required: each output column = 8e→db, 4d→13, a1→53, bc→45.
  - out_valid high exactly 5 edges after accept (1 edge with AES_INVMIX_PARALLEL_EN).
- Fixed points: in_state=128'h0101…01 with round_key=0 → out_state=128'h0101…01.
  - in_state=all c6 with round_key=0 → all c6.
- Last round: in_state=128'hFF…FF, round_key=128'h0F…0F, last_round=1 → out_state=128'hF0…F0 after 1 edge.
- Backpressure: hold out_ready=0 for 20 cycles while in_valid stays 1 with new data.
  - out_state stays stable and in_ready stays 0.
  - The next accept occurs only in the cycle after the out handshake.
- Reset mid-CALC: assert rst_n=0 at col==2, release 2 cycles later.
  - Required: no out_valid pulse and in_ready=1.
  - A fresh vector then completes with correct data.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// rtl/aes_dec_pkg.sv - shared types, GF(2^8) helpers and FSM states for the AES decryption datapath
package aes_dec_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } dec_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul_0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul_0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul_0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_add_mix_round_if.sv
// rtl/inv_add_mix_round_if.sv - input/output handshake bundle of the decryption round back-end
interface inv_add_mix_round_if;
    import aes_dec_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    state_t round_key;
    logic   last_round;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;

    // round controller side
    modport master (
        output in_valid, in_state, round_key, last_round, out_ready,
        input  in_ready, out_valid, out_state
    );

    // round back-end side
    modport slave (
        input  in_valid, in_state, round_key, last_round, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/inv_mix_column.sv
// rtl/inv_mix_column.sv - combinational InvMixColumns on one 32-bit column (byte 0 = row 0)
module inv_mix_column
    import aes_dec_pkg::*;
(
    input  col_t col_in,
    output col_t col_out
);

    logic [7:0] a [4];

    // row r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3)
    for (genvar r = 0; r < 4; r++) begin : g_row
        assign a[r] = col_in[8*r +: 8];
        assign col_out[8*r +: 8] = gmul_0e(a[r])
                                 ^ gmul_0b(a[(r + 1) % 4])
                                 ^ gmul_0d(a[(r + 2) % 4])
                                 ^ gmul_09(a[(r + 3) % 4]);
    end

endmodule

// File: rtl/inv_add_mix_round.sv
// rtl/inv_add_mix_round.sv - AddRoundKey + InvMixColumns round back-end; AES_INVMIX_PARALLEL_EN selects all-column build
module inv_add_mix_round
    import aes_dec_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    inv_add_mix_round_if.slave  bus
);

    dec_state_e state_q, state_d;
    state_t     work_q;
    state_t     key_sum;
    logic       accept;

    assign key_sum       = bus.in_state ^ bus.round_key;
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_state = work_q;

`ifdef AES_INVMIX_PARALLEL_EN
    state_t mixed;

    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_column u_imc (
            .col_in  (key_sum[32*c +: 32]),
            .col_out (mixed[32*c +: 32])
        );
    end

    // Whole round result is captured on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
        end else if (accept) begin
            work_q <= bus.last_round ? key_sum : mixed;
        end
    end
`else
    logic [1:0] col_q;
    logic [6:0] col_base;
    col_t       mix_in;
    col_t       mix_out;

    assign col_base = {col_q, 5'b0};
    assign mix_in   = work_q[col_base +: 32];

    inv_mix_column u_imc (
        .col_in  (mix_in),
        .col_out (mix_out)
    );

    // Load key-added state on accept, then rewrite one column per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            col_q  <= 2'd0;
        end else if (accept) begin
            work_q <= key_sum;
            col_q  <= 2'd0;
        end else if (state_q == CALC) begin
            work_q[col_base +: 32] <= mix_out;
            col_q                  <= col_q + 2'd1;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and accept decode
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
`ifdef AES_INVMIX_PARALLEL_EN
                    state_d = DONE;
`else
                    state_d = bus.last_round ? DONE : CALC;
`endif
                end
            end
            CALC: begin
`ifndef AES_INVMIX_PARALLEL_EN
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
`else
                state_d = DONE;
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_inv_add_mix_round.sv
// tb/tb_inv_add_mix_round.sv - directed self-checking bench for inv_add_mix_round
module tb_inv_add_mix_round;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

`ifdef AES_INVMIX_PARALLEL_EN
    localparam int LAT_MIX = 1;
`else
    localparam int LAT_MIX = 5;
`endif

    localparam logic [127:0] KV_IN   = 128'hbca14d8e_bca14d8e_bca14d8e_bca14d8e;
    localparam logic [127:0] KV_OUT  = 128'h455313db_455313db_455313db_455313db;
    localparam logic [127:0] ONES_01 = {16{8'h01}};
    localparam logic [127:0] ALL_C6  = {16{8'hc6}};
    localparam logic [127:0] ALL_FF  = {16{8'hff}};
    localparam logic [127:0] ALL_0F  = {16{8'h0f}};
    localparam logic [127:0] ALL_F0  = {16{8'hf0}};

    inv_add_mix_round_if bus ();

    inv_add_mix_round dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at #1 after a rising edge; runs one block through the handshake
    task automatic run_block(input string tag, input logic [127:0] st, input logic [127:0] key,
                             input logic last, input logic [127:0] exp, input int exp_lat);
        int lat;
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        bus.in_valid   = 1'b1;
        bus.in_state   = st;
        bus.round_key  = key;
        bus.last_round = last;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.in_state   = ~st;
        bus.round_key  = ~key;
        bus.last_round = ~last;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_data"}, bus.out_state, exp);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_back_idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
    endtask

    initial begin
        int lat;
        logic [127:0] held;
        bus.in_valid   = 1'b0;
        bus.in_state   = '0;
        bus.round_key  = '0;
        bus.last_round = 1'b0;
        bus.out_ready  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_state", bus.out_state, 128'h0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_in_ready", bus.in_ready, 1'b1);
        check("idle_out_valid", bus.out_valid, 1'b0);
        check("idle_out_state", bus.out_state, 128'h0);

        // Directed vectors
        run_block("known_vec", KV_IN, 128'h0, 1'b0, KV_OUT, LAT_MIX);
        run_block("fixed_01", ONES_01, 128'h0, 1'b0, ONES_01, LAT_MIX);
        run_block("fixed_c6", ALL_C6, 128'h0, 1'b0, ALL_C6, LAT_MIX);
        run_block("last_round", ALL_FF, ALL_0F, 1'b1, ALL_F0, 1);
        run_block("key_mix", KV_IN ^ ALL_0F, ALL_0F, 1'b0, KV_OUT, LAT_MIX);

        // Backpressure with in_valid held and new data every cycle
        bus.in_valid   = 1'b1;
        bus.in_state   = KV_IN;
        bus.round_key  = '0;
        bus.last_round = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            bus.in_state = bus.in_state + 128'd1;
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", lat, LAT_MIX);
        held = bus.out_state;
        check("bp_first_data", held, KV_OUT);
        for (int i = 0; i < 20; i++) begin
            bus.in_state = {4{$urandom}};
            @(posedge clk); #1;
            if (bus.out_state !== KV_OUT || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                check("bp_hold", {bus.out_valid, bus.in_ready, bus.out_state}, {2'b10, KV_OUT});
            end
        end
        check("bp_hold_end", {bus.out_valid, bus.in_ready, bus.out_state}, {2'b10, KV_OUT});
        bus.in_state   = ONES_01;
        bus.last_round = 1'b1;
        bus.out_ready  = 1'b1;
        @(posedge clk); #1;
        bus.out_ready  = 1'b0;
        check("bp_after_hs", {bus.in_ready, bus.out_valid, bus.out_state}, {2'b10, KV_OUT});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_next_accept", {bus.out_valid, bus.out_state}, {1'b1, ONES_01});
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;

        // Reset in the middle of the column pass
        bus.in_valid   = 1'b1;
        bus.in_state   = KV_IN;
        bus.round_key  = '0;
        bus.last_round = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_async", {bus.in_ready, bus.out_valid, bus.out_state}, {2'b10, 128'h0});
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) check("midrst_held", bus.out_valid, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) check("midrst_no_pulse", bus.out_valid, 1'b0);
        end
        check("midrst_ready", {bus.in_ready, bus.out_valid}, 2'b10);
        run_block("post_rst", KV_IN, 128'h0, 1'b0, KV_OUT, LAT_MIX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
